// File: rtl/block_b_if.sv
// Output stream bundle for block_b: valid/ready handshake, packed word
// and end-of-frame marker. The master side is the producer (block_b).
interface block_b_if #(
  parameter int W = 9
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/block_b.sv
// block_b: packs qualified block_a samples into words, buffers them in a
// small FIFO and drains them over a valid/ready stream with fixed-length
// framing. Samples arriving while the FIFO is full are dropped and counted,
// so the upstream stage never sees backpressure.
// Optional feature: define BLOCK_B_PARITY_EN to add an out_parity port with
// even parity of out_data, computed at push time and stored alongside.
module block_b #(
  parameter int DATA2      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               data_en,
  input  logic [2:0]         data_out_t_7,
  input  logic [1:0]         data_out_1,
  input  logic [DATA2:0]     data_out_t_2,
  input  logic               flush,
  block_b_if.master          out_bus,
  output logic [CNT_W-1:0]   drop_cnt
`ifdef BLOCK_B_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  localparam int SAMPLE_W = 3 + 2 + (DATA2 + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef BLOCK_B_PARITY_EN
  localparam int ENTRY_W  = SAMPLE_W + 1;
`else
  localparam int ENTRY_W  = SAMPLE_W;
`endif

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [SAMPLE_W-1:0] sample;
  logic [ENTRY_W-1:0]  entry;
  logic [ENTRY_W-1:0]  head;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic                drop;
  state_t              state;
  logic [CW-1:0]       count;

  assign sample = {data_out_t_7, data_out_1, data_out_t_2};
`ifdef BLOCK_B_PARITY_EN
  assign entry  = {^sample, sample};
`else
  assign entry  = sample;
`endif

  // Extra pointer bit tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push  = clk_en & data_en;
  assign pop   = out_bus.out_valid & out_bus.out_ready;
  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign wr_en = push & (!full | pop) & !flush;
  assign drop  = push & full & !pop & !flush;

  assign head  = mem[rd_ptr[AW-1:0]];

  assign out_bus.out_valid = !empty;
  assign out_bus.out_data  = empty ? '0 : head[SAMPLE_W-1:0];
  assign out_bus.out_last  = !empty && (count == CW'(FRAME_LEN - 1));
`ifdef BLOCK_B_PARITY_EN
  assign out_parity        = !empty & head[SAMPLE_W];
`endif

  // Storage array; contents are don't-care until written, reads are gated.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= entry;
  end

  // Read/write pointers; flush empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Saturating overflow counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Frame FSM: counts popped words and wraps after FRAME_LEN of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else if (pop) begin
      case (state)
        IDLE: begin
          if (FRAME_LEN == 1) begin
            state <= IDLE;
            count <= '0;
          end else begin
            state <= ACTIVE;
            count <= CW'(1);
          end
        end
        ACTIVE: begin
          if (count == CW'(FRAME_LEN - 1)) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_b.sv
// Directed testbench for block_b at default parameters.
module tb_block_b;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       data_en;
  logic [2:0] data_out_t_7;
  logic [1:0] data_out_1;
  logic [3:0] data_out_t_2;
  logic       flush;
  logic [7:0] drop_cnt;
`ifdef BLOCK_B_PARITY_EN
  logic       out_parity;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  block_b_if #(.W(9)) bus ();

  block_b dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .data_en      (data_en),
    .data_out_t_7 (data_out_t_7),
    .data_out_1   (data_out_1),
    .data_out_t_2 (data_out_t_2),
    .flush        (flush),
    .out_bus      (bus),
    .drop_cnt     (drop_cnt)
`ifdef BLOCK_B_PARITY_EN
    ,
    .out_parity   (out_parity)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] word(input int a, input int b, input int c);
    logic [2:0] fa;
    logic [1:0] fb;
    logic [3:0] fc;
    fa = 3'(a);
    fb = 2'(b);
    fc = 4'(c);
    return {fa, fb, fc};
  endfunction

  task automatic apply_stimulus(input logic ce, input logic de, input int a, input int b,
                                input int c, input logic rdy, input logic fl);
    clk_en       = ce;
    data_en      = de;
    data_out_t_7 = 3'(a);
    data_out_1   = 2'(b);
    data_out_t_2 = 4'(c);
    bus.out_ready = rdy;
    flush        = fl;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      miss_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    #12;
    check_output("reset_valid", 32'(bus.out_valid), 0);
    check_output("reset_last", 32'(bus.out_last), 0);
    check_output("reset_data", 32'(bus.out_data), 0);
    check_output("reset_drop", 32'(drop_cnt), 0);
`ifdef BLOCK_B_PARITY_EN
    check_output("reset_parity", 32'(out_parity), 0);
`endif
    rst = 1'b1;
    tick();

    // Basic latency: one push, visible next cycle, popped immediately
    apply_stimulus(1, 1, 3'b101, 2'b10, 4'hC, 1, 0);
    check_output("basic_no_bypass", 32'(bus.out_valid), 0);
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    check_output("basic_valid", 32'(bus.out_valid), 1);
    check_output("basic_data", 32'(bus.out_data), 32'h16C);
`ifdef BLOCK_B_PARITY_EN
    check_output("basic_parity", 32'(out_parity), 1);
`endif
    tick();
    check_output("basic_empty", 32'(bus.out_valid), 0);
    check_output("basic_data_zero", 32'(bus.out_data), 0);
`ifdef BLOCK_B_PARITY_EN
    check_output("empty_parity", 32'(out_parity), 0);
`endif
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    tick();

    // Overflow: six pushes into four entries, two dropped
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1, 1, i, 0, i, 0, 0);
      tick();
    end
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    check_output("ovf_drop", 32'(drop_cnt), 2);
    check_output("ovf_hold_data", 32'(bus.out_data), 32'(word(0, 0, 0)));
    tick();
    check_output("ovf_hold_again", 32'(bus.out_data), 32'(word(0, 0, 0)));
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check_output("ovf_valid", 32'(bus.out_valid), 1);
      check_output("ovf_data", 32'(bus.out_data), 32'(word(i, 0, i)));
      check_output("ovf_last", 32'(bus.out_last), (i == 3) ? 1 : 0);
      tick();
    end
    check_output("ovf_drained", 32'(bus.out_valid), 0);

    // Full with simultaneous pop: push accepted each cycle, no drops
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 1, k, 1, k + 2, 0, 0);
      tick();
    end
    for (int k = 4; k < 14; k++) begin
      apply_stimulus(1, 1, k, 1, k + 2, 1, 0);
      check_output("fullpop_valid", 32'(bus.out_valid), 1);
      check_output("fullpop_data", 32'(bus.out_data), 32'(word(k - 4, 1, k - 2)));
      tick();
    end
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    check_output("fullpop_drop", 32'(drop_cnt), 2);
    for (int k = 10; k < 14; k++) begin
      check_output("fullpop_tail", 32'(bus.out_data), 32'(word(k, 1, k + 2)));
      tick();
    end
    check_output("fullpop_empty", 32'(bus.out_valid), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    tick();

    // Framing: nine streamed words, out_last on 4 and 8
    for (int n = 0; n < 10; n++) begin
      apply_stimulus(1, (n < 9) ? 1'b1 : 1'b0, n, 2, n + 5, 1, 0);
      if (n >= 1) begin
        check_output("frame_valid", 32'(bus.out_valid), 1);
        check_output("frame_data", 32'(bus.out_data), 32'(word(n - 1, 2, n + 4)));
        check_output("frame_last", 32'(bus.out_last), (n % 4 == 0) ? 1 : 0);
      end
      tick();
    end
    check_output("frame_empty", 32'(bus.out_valid), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int n = 0; n < 5; n++) begin
      apply_stimulus(1, (n < 4) ? 1'b1 : 1'b0, n, 3, n, 1, 0);
      if (n >= 1) begin
        check_output("reframe_last", 32'(bus.out_last), (n == 4) ? 1 : 0);
      end
      tick();
    end

    // Flush while full with a push: no drop counted, FIFO empties
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 1, k, 0, k, 0, 0);
      tick();
    end
    apply_stimulus(1, 1, 7, 3, 15, 0, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("flush_empty", 32'(bus.out_valid), 0);
    check_output("flush_drop_kept", 32'(drop_cnt), 2);

    // Mid-operation reset: three queued, frame ACTIVE
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 1, k, 1, k, 0, 0);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("mid_valid_before", 32'(bus.out_valid), 1);
    #2 rst = 1'b0;
    #1;
    check_output("mid_valid", 32'(bus.out_valid), 0);
    check_output("mid_drop", 32'(drop_cnt), 0);
    check_output("mid_last", 32'(bus.out_last), 0);
    check_output("mid_data", 32'(bus.out_data), 0);
    #1 rst = 1'b1;
    tick();

    // clk_en low blocks pushes but the drain continues
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1, 1, k + 4, 2, k + 9, 0, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 1, 7, 3, 15, 1, 0);
      if (k < 2) begin
        check_output("ce_drain_data", 32'(bus.out_data), 32'(word(k + 4, 2, k + 9)));
        check_output("ce_drain_last", 32'(bus.out_last), 0);
      end else begin
        check_output("ce_no_push", 32'(bus.out_valid), 0);
      end
      tick();
    end

    // Drop counter saturates at 255
    for (int k = 0; k < 264; k++) begin
      apply_stimulus(1, 1, k, 0, k, 0, 0);
      tick();
    end
    check_output("drop_saturate", 32'(drop_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
